// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and default parameters for the program sequencer
package pc_pkg;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_SEQ,
        PC_BR,
        PC_JMP,
        PC_CALL,
        PC_RET
    } pc_sel_t;

    localparam int PC_A_DEF  = 10;
    localparam int PC_D_DEF  = 4;
    localparam int PC_OW_DEF = 8;
    localparam int PC_CW_DEF = 16;

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - return-address LIFO with combinational top-of-stack read
module ret_stack #(
    parameter int A = 10,
    parameter int D = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [A-1:0]             din,
    output logic [A-1:0]             dout,
    output logic [$clog2(D+1)-1:0]   depth,
    output logic                     full,
    output logic                     empty
);
    localparam int DW = $clog2(D+1);

    logic [DW-1:0] depth_q, depth_d;
    logic [A-1:0]  mem_q [D];
    logic [A-1:0]  mem_d [D];

    assign full  = (depth_q == DW'(D));
    assign empty = (depth_q == '0);
    assign depth = depth_q;

    always_comb begin
        mem_d   = mem_q;
        dout    = '0;
        depth_d = depth_q;
        for (int i = 0; i < D; i++) begin
            if (push && !full && depth_q == DW'(i))
                mem_d[i] = din;
            // Top of stack lives at depth-1, read without a clock so a return is single-cycle
            if (depth_q == DW'(i + 1))
                dout = mem_q[i];
        end
        if (push && !full)
            depth_d = depth_q + DW'(1);
        else if (pop && !empty)
            depth_d = depth_q - DW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            depth_q <= '0;
        else
            depth_q <= depth_d;
    end

    // Contents need no reset: depth alone decides what is valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program counter, call/return stack, halt flags and cycle counter
module pc_seq
    import pc_pkg::*;
#(
    parameter int A  = PC_A_DEF,
    parameter int D  = PC_D_DEF,
    parameter int OW = PC_OW_DEF,
    parameter int CW = PC_CW_DEF
) (
    input  logic                   CLK,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   done,
    input  logic                   jump_en,
    input  logic                   branch_en,
    input  logic                   call_en,
    input  logic                   ret_en,
    input  logic [A-1:0]           target,
    input  logic [OW-1:0]          offset,
    output logic [A-1:0]           pc,
    output logic                   halt,
    output logic                   stack_err,
    output logic [$clog2(D+1)-1:0] depth,
    output logic [CW-1:0]          cycle_ct
);
    pc_sel_t        sel;
    logic           set_halt, set_err;
    logic [A-1:0]   pc_q, pc_d;
    logic           halt_q, halt_d;
    logic           err_q, err_d;
    logic [CW-1:0]  ct_q, ct_d;
    logic [A-1:0]   stk_top;
    logic           stk_full, stk_empty;
    logic [A-1:0]   off_ext;

    assign off_ext = A'($signed(offset));

    // Priority decode: only the highest request acts, the rest are dropped silently
    always_comb begin
        sel      = PC_SEQ;
        set_halt = 1'b0;
        set_err  = 1'b0;
        if (halt_q || stall) begin
            sel = PC_HOLD;
        end else if (done) begin
            sel      = PC_HOLD;
            set_halt = 1'b1;
        end else if (ret_en) begin
            if (stk_empty) begin
                sel      = PC_HOLD;
                set_halt = 1'b1;
                set_err  = 1'b1;
            end else begin
                sel = PC_RET;
            end
        end else if (call_en) begin
            if (stk_full) begin
                sel      = PC_HOLD;
                set_halt = 1'b1;
                set_err  = 1'b1;
            end else begin
                sel = PC_CALL;
            end
        end else if (jump_en) begin
            sel = PC_JMP;
        end else if (branch_en) begin
            sel = PC_BR;
        end
    end

    always_comb begin
        pc_d = pc_q;
        case (sel)
            PC_SEQ:  pc_d = pc_q + A'(1);
            PC_BR:   pc_d = pc_q + off_ext;
            PC_JMP:  pc_d = target;
            PC_CALL: pc_d = target;
            PC_RET:  pc_d = stk_top;
            default: pc_d = pc_q;
        endcase
        halt_d = halt_q | set_halt;
        err_d  = err_q | set_err;
        ct_d   = (!halt_q && ct_q != '1) ? ct_q + CW'(1) : ct_q;
    end

    always_ff @(posedge CLK or posedge start) begin
        if (start) begin
            pc_q   <= '0;
            halt_q <= 1'b0;
            err_q  <= 1'b0;
            ct_q   <= '0;
        end else begin
            pc_q   <= pc_d;
            halt_q <= halt_d;
            err_q  <= err_d;
            ct_q   <= ct_d;
        end
    end

    ret_stack #(.A(A), .D(D)) u_stack (
        .clk   (CLK),
        .rst   (start),
        .push  (sel == PC_CALL),
        .pop   (sel == PC_RET),
        .din   (pc_q + A'(1)),
        .dout  (stk_top),
        .depth (depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign pc        = pc_q;
    assign halt      = halt_q;
    assign stack_err = err_q;
    assign cycle_ct  = ct_q;

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-sequencing unit for the accumulator processor: holds the program counter, resolves jump/branch/call/return/halt requests from `Ctrl` each cycle, and keeps a hardware return-address stack and a cycle counter. It replaces the fixed 10-bit PC plus the free-running counter in the top level. Its output `pc` drives the instruction ROM address, and `halt` is the DUT done flag.

## Interface
- `A`, default 10: PC / instruction-address width.
- `D`, default 4: return-stack depth (entries), ≥1.
- `OW`, default 8: signed branch-offset width, ≤ `A`.
- `CW`, default 16: cycle-counter width.

Ports:
- `CLK`  in  1  clock; all state changes on posedge.
- `start`  in  1  reset; asynchronous, active-high.
- `stall`  in  1  freeze PC and stack this cycle (e.g. multi-cycle memory).
- `done`  in  1  program-end request from `Ctrl`.
- `jump_en`  in  1  absolute jump to `target`.
- `branch_en`  in  1  relative branch by `offset`.
- `call_en`  in  1  push return address, jump to `target`.
- `ret_en`  in  1  pop return address into PC.
- `target`  in  A  absolute destination from the jump LUT.
- `offset`  in  OW  signed two's-complement branch offset.
- `pc`  out  A  current program count.
- `halt`  out  1  sticky stop flag.
- `stack_err`  out  1  sticky overflow/underflow flag.
- `depth`  out  $clog2(D+1)  entries currently on the stack.
- `cycle_ct`  out  CW  cycles executed since reset.

## Operation
- Reset (`start`=1, asynchronous): `pc`=0, `halt`=0, `stack_err`=0, `depth`=0, `cycle_ct`=0. Stack contents are don't-care.
- Per-cycle priority, highest first: `halt` > `stall` > `done` > `ret_en` > `call_en` > `jump_en` > `branch_en` > sequential.
- Halted: all state frozen, including `cycle_ct`. Only reset clears `halt`.
- Stall: `pc`, stack and `depth` are held. `cycle_ct` still increments.
- `done`: `halt` is set. `pc` is held.
- Return:
  - `depth`>0: `pc` ← top of stack, `depth`−1.
  - `depth`=0 (underflow): `stack_err`=1, `halt`=1, `pc` held.
- Call:
  - `depth`<D: push `pc`+1 (mod 2^A), `pc` ← `target`, `depth`+1.
  - `depth`=D (overflow): `stack_err`=1, `halt`=1, `pc` held, stack unchanged.
- Jump: `pc` ← `target`.
- Branch: `pc` ← `pc` + sign-extended `offset`, modulo 2^A. Wraps in both directions.
- Sequential: `pc` ← `pc`+1. `2^A−1` wraps to 0.
- Simultaneous requests: only the highest-priority one acts. Lower ones are silently dropped, with no error.
- `cycle_ct` increments every non-halted cycle and saturates at 2^CW−1; it does not wrap.

## Timing
- All outputs are registered. A request sampled at edge k is visible on `pc`/`depth`/`halt` after edge k. Single-cycle latency, no bubbles.
- `pc` is valid throughout the cycle for the combinational ROM read.
- `halt` rises on the edge after the sampled `done` or error. `pc` then shows the address of the instruction that raised it.
- Stack read is combinational from `depth`−1, so a return completes in one cycle.
- Back-to-back call/ret on consecutive cycles is legal; there is no stack-turnaround penalty.
- Reset asserted mid-operation takes effect immediately (asynchronous). The first sequential increment happens on the first posedge after deassertion.

## Structure
- Package `pc_pkg`:
  - enum `pc_sel_t` {`PC_HOLD`, `PC_SEQ`, `PC_BR`, `PC_JMP`, `PC_CALL`, `PC_RET`}.
  - Default parameter constants.
- Sub-module `ret_stack` (LIFO, parameters `A`, `D`):
  - Inputs: `push`, `pop`, `din`.
  - Outputs: `dout`, `depth`, `full`, `empty`.
  - Async reset clears `depth` only.
- `pc_seq` contains:
  - a combinational priority decoder producing `pc_sel_t`;
  - the PC register;
  - the halt/error flags;
  - the saturating counter.

## Test plan
- Reset, then 5 idle cycles → `pc` = 0,1,2,3,4,5; `cycle_ct`=5; `halt`=0.
- With `pc`=3, `branch_en`, `offset`=−5, A=10 → `pc`=1022. From `pc`=1023 sequential → `pc`=0.
- `call_en` with `target`=100 at `pc`=7; 2 cycles later `ret_en` → `pc`=100, 101, then 8; `depth` 1, 1, 0.
- D=4: five nested calls → 5th sets `stack_err`=1 and `halt`=1, `pc` frozen at the caller, `depth`=4. `ret_en` at `depth`=0 after reset → `stack_err`=1, `halt`=1.
- `stall` held 3 cycles with `jump_en` active → `pc` unchanged, `cycle_ct` +3. Then `jump_en` alone → `pc`=`target`. `done` together with `jump_en` → `halt`=1, `pc` unchanged.
- CW=4: run 20 cycles → `cycle_ct` saturates at 15. Assert `start` mid-cycle → all outputs 0 before the next edge.
